// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the UART transmit port and uart_tx_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_valid;
  logic                          tx_ready;

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ready, tx_data, tx_valid
  );

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmit byte port between NUM_REQ sources.
// Define UART_TX_ARB_HEADER_EN to prefix every grant with a 0xA0|id source-ID header byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BEATS + 1);

`ifdef UART_TX_ARB_HEADER_EN
  if (DATA_WIDTH != 8 || NUM_REQ > 16) begin : g_bad_header_cfg
    $error("uart_tx_arbiter: header byte needs DATA_WIDTH==8 and NUM_REQ<=16");
  end
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef UART_TX_ARB_HEADER_EN
    HEADER = 2'd2,
`endif
    STREAM = 2'd1
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_grant_q, last_grant_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [GW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    req_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;

  // Round-robin search starting just after the previous owner; modulo keeps
  // non-power-of-two NUM_REQ correct.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!pick_found && bus.req_valid[(int'(last_grant_q) + k) % NUM_REQ]) begin
        pick_found = 1'b1;
        pick_idx   = GW'((int'(last_grant_q) + k) % NUM_REQ);
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    tx_valid     = 1'b0;
    tx_data      = '0;
    req_ready    = '0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
`ifdef UART_TX_ARB_HEADER_EN
          state_d    = HEADER;
`else
          state_d    = STREAM;
`endif
        end
      end

`ifdef UART_TX_ARB_HEADER_EN
      HEADER: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = DATA_WIDTH'({4'hA, 4'(grant_id_q)});
        if (bus.tx_ready) state_d = STREAM;
      end
`endif

      STREAM: begin
        busy                  = 1'b1;
        tx_valid              = bus.req_valid[grant_id_q];
        req_ready[grant_id_q] = bus.tx_ready;
        if (tx_valid) tx_data = bus.req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
        if (tx_valid && bus.tx_ready) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          // Release on end of packet or at the beat limit; the rest of a
          // truncated packet re-enters arbitration as a fresh grant.
          if (bus.req_last[grant_id_q] || beat_cnt_q == CW'(MAX_BEATS - 1)) begin
            last_grant_d = grant_id_q;
            state_d      = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.tx_data   = tx_data;
  assign bus.tx_valid  = tx_valid;
  assign grant_id      = grant_id_q;

endmodule
